// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer and its flag generator.
package alu_op_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;

  typedef struct packed {
    logic z;
    logic c;
    logic s;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_op_sequencer_flag_gen.sv
// Combinational zero/carry/sign/overflow derivation from the adder sum and operand MSBs.
module alu_flag_gen
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             amod_msb,
  input  logic             bmod_msb,
  output alu_flags_t       flags
);

  always_comb begin
    flags   = '0;
    flags.z = (sum == '0);
    flags.c = cout;
    flags.s = sum[WIDTH-1];
    // Two's-complement overflow: like-signed inputs producing an opposite-signed sum.
    flags.v = (amod_msb == bmod_msb) && (sum[WIDTH-1] != amod_msb);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-request execution wrapper around the combinational preprocess/adder datapath.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [2:0]       in_Op,
  output logic [WIDTH-1:0] A_q,
  output logic [WIDTH-1:0] B_q,
  output logic [2:0]       Op_q,
  input  logic             amod_msb,
  input  logic             bmod_msb,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_s,
  output logic             flag_v
);

  seq_state_t state;
  logic [3:0] count;
  alu_flags_t flags;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .sum      (sum),
    .cout     (cout),
    .amod_msb (amod_msb),
    .bmod_msb (bmod_msb),
    .flags    (flags)
  );

  assign in_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      A_q       <= '0;
      B_q       <= '0;
      Op_q      <= '0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_s    <= 1'b0;
      flag_v    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            A_q   <= in_A;
            B_q   <= in_B;
            Op_q  <= in_Op;
            count <= 4'(EXEC_CYCLES - 1);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (count != '0) begin
            count <= count - 4'd1;
          end else begin
            result    <= sum;
            flag_z    <= flags.z;
            flag_c    <= flags.c;
            flag_s    <= flags.s;
            flag_v    <= flags.v;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench: two sequencers (EXEC_CYCLES 1 and 3) driving a preprocess+adder environment, checked against a transaction-level model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;

  logic       in_ready [2];
  logic       res_valid[2];
  logic [3:0] a_q[2], b_q[2], result[2], amod[2], bmod[2], sum[2];
  logic [2:0] op_q[2];
  logic       cout[2], fz[2], fc[2], fs[2], fv[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Environment: preprocess operand shaping for the four defined ops
  function automatic logic [7:0] pre(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'b000:  pre = {a, 4'h0};
      3'b001:  pre = {4'h1, ~a};
      3'b011:  pre = {a, 4'h1};
      default: pre = {a, b};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned EC = (g == 0) ? 1 : 3;
    assign {amod[g], bmod[g]} = pre(a_q[g], b_q[g], op_q[g]);
    assign {cout[g], sum[g]}  = 5'(amod[g]) + 5'(bmod[g]);
    alu_op_sequencer #(.WIDTH(4), .EXEC_CYCLES(EC)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_A(in_a), .in_B(in_b), .in_Op(in_op),
      .A_q(a_q[g]), .B_q(b_q[g]), .Op_q(op_q[g]),
      .amod_msb(amod[g][3]), .bmod_msb(bmod[g][3]), .sum(sum[g]), .cout(cout[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready), .result(result[g]),
      .flag_z(fz[g]), .flag_c(fc[g]), .flag_s(fs[g]), .flag_v(fv[g])
    );
  end

  // Reference: integer arithmetic on the shaped operands; returns {res, z, c, s, v}
  function automatic bit [7:0] ref_calc(input bit [3:0] a, input bit [3:0] b, input bit [2:0] op);
    int x, y, t, sx, sy, st;
    case (op)
      3'd0:    begin x = a; y = 0; end
      3'd1:    begin x = 1; y = 15 - a; end
      3'd3:    begin x = a; y = 1; end
      default: begin x = a; y = b; end
    endcase
    t  = x + y;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    st = sx + sy;
    ref_calc = {4'(t % 16), bit'((t % 16) == 0), bit'(t >= 16), bit'((t % 16) >= 8),
                bit'(st > 7 || st < -8)};
  endfunction

  typedef struct packed {
    bit [3:0] a, b, res;
    bit [2:0] op;
    bit z, c, s, v, rv;
  } exp_t;

  exp_t m[2];
  bit   busy[2];
  int   age[2];
  int   ncyc = 0;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      automatic exp_t n;
      automatic bit nb;
      automatic int na;
      automatic bit [7:0] r;
      n  = m[g];
      nb = busy[g];
      na = age[g];
      if (reset) begin
        n = '0; nb = 1'b0; na = 0;
      end else if (!busy[g]) begin
        if (in_valid) begin
          nb = 1'b1; na = 0; n.a = in_a; n.b = in_b; n.op = in_op;
        end
      end else if (!m[g].rv) begin
        na = age[g] + 1;
        if (na == ((g == 0) ? 1 : 3)) begin
          r = ref_calc(m[g].a, m[g].b, m[g].op);
          {n.res, n.z, n.c, n.s, n.v} = r;
          n.rv = 1'b1;
        end
      end else if (res_ready) begin
        n.rv = 1'b0; nb = 1'b0;
      end
      m[g]    <= n;
      busy[g] <= nb;
      age[g]  <= na;
    end
    ncyc <= ncyc + 1;
  end

  task automatic chk(input string name, input int g, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, g, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ncyc > 0) begin
      for (int g = 0; g < 2; g++) begin
        chk("in_ready",  g, {7'd0, in_ready[g]},  {7'd0, !busy[g] && !reset});
        chk("res_valid", g, {7'd0, res_valid[g]}, {7'd0, m[g].rv});
        chk("operands",  g, {a_q[g], b_q[g]},     {m[g].a, m[g].b});
        chk("op_q",      g, {5'd0, op_q[g]},      {5'd0, m[g].op});
        chk("result",    g, {4'd0, result[g]},    {4'd0, m[g].res});
        chk("flags",     g, {4'd0, fz[g], fc[g], fs[g], fv[g]}, {4'd0, m[g].z, m[g].c, m[g].s, m[g].v});
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    res_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    while (!(in_ready[0] && in_ready[1]) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 0, {7'd0, in_ready[0] && in_ready[1]}, 8'd1);
  endtask

  // Accept on both instances, then pin latency and result of each against literal values
  task automatic lit_req(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] er, input logic [3:0] ef);
    wait_idle();
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lit_busy", 0, {7'd0, in_ready[0]}, 8'd0);
    @(negedge clk);
    chk("lit_rv1", 0, {7'd0, res_valid[0]}, 8'd1);
    chk("lit_res", 0, {4'd0, result[0]}, {4'd0, er});
    chk("lit_flg", 0, {4'd0, fz[0], fc[0], fs[0], fv[0]}, {4'd0, ef});
    chk("lit_rv3_early", 1, {7'd0, res_valid[1]}, 8'd0);
    @(negedge clk);
    chk("lit_ready_back", 0, {7'd0, in_ready[0]}, 8'd1);
    chk("lit_rv3_early", 1, {7'd0, res_valid[1]}, 8'd0);
    @(negedge clk);
    chk("lit_rv3", 1, {7'd0, res_valid[1]}, 8'd1);
    chk("lit_res", 1, {4'd0, result[1]}, {4'd0, er});
    chk("lit_flg", 1, {4'd0, fz[1], fc[1], fs[1], fv[1]}, {4'd0, ef});
  endtask

  initial begin
    @(posedge clk); @(negedge clk);
    chk("rst_ready", 0, {7'd0, in_ready[0]}, 8'd0);
    chk("rst_result", 0, {4'd0, result[0]}, 8'd0);
    @(posedge clk); #1 reset = 1'b0;

    // flags packed {z,c,s,v}
    lit_req(4'd3, 4'd4, 3'b010, 4'h7, 4'b0000);
    lit_req(4'd7, 4'd1, 3'b010, 4'h8, 4'b0011);
    lit_req(4'd8, 4'd8, 3'b010, 4'h0, 4'b1101);
    lit_req(4'd0, 4'd5, 3'b001, 4'h0, 4'b1100);
    lit_req(4'd1, 4'd5, 3'b001, 4'hF, 4'b0010);
    lit_req(4'hF, 4'd2, 3'b011, 4'h0, 4'b1100);

    // Backpressure: hold results while a new request waits
    wait_idle();
    res_ready = 1'b0;
    in_a = 4'd5; in_b = 4'd6; in_op = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1 in_a = 4'd9; in_b = 4'd2;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("bp_result", g, {4'd0, result[g]}, 8'h0B);
        chk("bp_flags", g, {4'd0, fz[g], fc[g], fs[g], fv[g]}, 8'b0011);
        chk("bp_ready", g, {7'd0, in_ready[g]}, 8'd0);
        chk("bp_a", g, {4'd0, a_q[g]}, 8'd5);
      end
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_a", 0, {a_q[0], b_q[0]}, 8'h92);

    // Reset during EXEC of the 3-cycle instance
    wait_idle();
    in_a = 4'd6; in_b = 4'd3; in_op = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rm_ready_low", 1, {7'd0, in_ready[1]}, 8'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rm_result", 1, {4'd0, result[1]}, 8'd0);
    chk("rm_aq", 1, {a_q[1], b_q[1]}, 8'd0);
    chk("rm_ready", 1, {7'd0, in_ready[1]}, 8'd1);
    chk("rm_ready", 0, {7'd0, in_ready[0]}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rm_no_rv", 1, {7'd0, res_valid[1]}, 8'd0);
    end

    // Random traffic, including occasional resets
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      res_ready = ($urandom_range(0, 9) < 7);
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      in_op     = 3'($urandom_range(0, 3));
    end
    reset = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control and register stage directly upstream of preprocess, with a result-capture path downstream of the adder.
- Accepts an operation request (A, B, Op) over a valid/ready handshake and holds the operands stable on the preprocess inputs.
- Waits a configurable settle time, then captures the adder sum plus carry/zero/sign/overflow flags.
- Presents the captured result over a second valid/ready handshake. Turns the combinational 4-bit ALU into a one-request-at-a-time execution unit.

Parameters:
- WIDTH, 4, operand/result width; must equal the preprocess/adder width.
- EXEC_CYCLES, 1, cycles operands are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_A  in  WIDTH  operand A.
- in_B  in  WIDTH  operand B.
- in_Op  in  3  operation code, same encoding as preprocess Op.
- A_q  out  WIDTH  registered A, drives preprocess A.
- B_q  out  WIDTH  registered B, drives preprocess B.
- Op_q  out  3  registered Op, drives preprocess Op.
- amod_msb  in  1  AMod[WIDTH-1] from preprocess.
- bmod_msb  in  1  BMod[WIDTH-1] from preprocess.
- sum  in  WIDTH  adder sum (AMod+BMod, cin=0).
- cout  in  1  adder carry out.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- result  out  WIDTH  captured sum.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.
- flag_s  out  1  sign flag.
- flag_v  out  1  overflow flag.

Behaviour:
- Reset (reset=1 at a clk edge):
  - State goes to IDLE; counter=0.
  - A_q, B_q, Op_q, result and all flags become 0; res_valid=0.
  - in_ready=0 while reset is high.
- Reset priority: reset has priority over every other event, including mid-EXEC and mid-DONE. A pending result is discarded, and no handshake completes on a reset edge.
- States: IDLE, EXEC, DONE, with 2-bit encoding.
- in_ready = (state==IDLE) & ~reset; combinational from the state register only, never from in_valid.
- IDLE:
  - on in_valid & in_ready, register in_A/in_B/in_Op into A_q/B_q/Op_q, load counter = EXEC_CYCLES-1, go to EXEC.
  - otherwise remain in IDLE with all registers held.
- EXEC:
  - A_q/B_q/Op_q are held.
  - If counter != 0: decrement and stay in EXEC.
  - If counter == 0: capture result=sum, flag_c=cout, flag_z=(sum==0), flag_s=sum[WIDTH-1], flag_v=(amod_msb==bmod_msb)&(sum[WIDTH-1]!=amod_msb); go to DONE.
- DONE:
  - res_valid=1 (registered, asserted the same edge as the capture).
  - result, flags and operand registers are held stable while res_ready=0.
  - On res_valid & res_ready: res_valid=0 and go to IDLE.
  - in_valid is ignored in DONE.
- Latency: request accepted at edge k; result valid after edge k+EXEC_CYCLES.
- Throughput: minimum one request per EXEC_CYCLES+2 cycles.
- Result and flags keep their last values after leaving DONE until the next capture. They are only meaningful while res_valid=1.
- Widths: flags are computed on the WIDTH-bit sum only; no sign extension; wrap-around is modulo 2^WIDTH, reported through flag_c/flag_v.
- in_A/in_B/in_Op may change freely outside the accepting edge.

Decomposition:
- Shared include file holds:
  - state encodings IDLE=2'b00, EXEC=2'b01, DONE=2'b10;
  - Op code constants (OP_PASS=3'b000, OP_NEG=3'b001, OP_ADD=3'b010, OP_INC=3'b011);
  - default WIDTH.
- One combinational sub-module, alu_flag_gen, computes z/c/s/v from sum, cout, amod_msb and bmod_msb. The sequencer registers its outputs on capture.

Test Plan:
- Bench wiring: the bench instantiates alu_op_sequencer feeding preprocess and the existing 4-bit adder, with cin=0.
- 1. Basic add: Op=010, A=3, B=4, res_ready=1, EXEC_CYCLES=1 -> in_ready drops after the accept edge; res_valid is high one edge later; result=7, z=0, c=0, s=0, v=0; in_ready returns 1 two edges after accept.
- 2. Signed overflow: Op=010, A=7, B=1 -> result=8, s=1, v=1, c=0, z=0. Then A=8, B=8 -> result=0, z=1, c=1, v=1.
- 3. Negate zero: Op=001, A=0 (AMod=1, BMod=F) -> result=0, z=1, c=1, v=0. Then A=1 -> result=F, s=1, c=0.
- 4. Backpressure: complete the add 5+6, hold res_ready=0 for 5 cycles while in_valid=1 with new operands -> result=B and flags stay constant, in_ready=0, no new accept. Raise res_ready -> one handshake, then the next request is accepted.
- 5. Settle timing: EXEC_CYCLES=3, Op=011, A=F -> res_valid rises exactly 3 edges after accept; result=0, c=1, z=1.
- 6. Reset mid-operation: EXEC_CYCLES=3, assert reset for one cycle during EXEC -> next cycle state IDLE, res_valid=0, result/flags/A_q/B_q/Op_q=0, in_ready=1 after reset deasserts, no spurious res_valid.
